// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: fixed-latency load/store
// against a little-endian byte-addressed array, stalling the pipeline while busy.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] read_data
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] LIMIT    = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [1:0]  size_q;
  logic [63:0] read_data_q;
  logic        resp_valid_q;
  logic        resp_err_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [2:0]    lane;
  logic [5:0]    shamt;
  logic [7:0]    size_mask;
  logic [2:0]    align_mask;
  logic [7:0]    byte_en;
  logic          acc_err;
  logic          access_now;
  logic [63:0]   wdata_shifted;
  logic [63:0]   rd_shifted;
  logic [63:0]   load_data;

  // Everything below is decoded from the captured request only.
  always_comb begin
    word_idx   = addr_q[3 +: AW];
    lane       = addr_q[2:0];
    shamt      = {lane, 3'b000};
    size_mask  = 8'hFF;
    align_mask = 3'b111;
    case (size_q)
      2'd0:    begin size_mask = 8'h01; align_mask = 3'b000; end
      2'd1:    begin size_mask = 8'h03; align_mask = 3'b001; end
      2'd2:    begin size_mask = 8'h0F; align_mask = 3'b011; end
      default: begin size_mask = 8'hFF; align_mask = 3'b111; end
    endcase
    acc_err       = (|(lane & align_mask)) || (addr_q >= LIMIT);
    access_now    = (state_q == BUSY) && (cnt_q == 4'd0);
    byte_en       = size_mask << lane;
    wdata_shifted = wdata_q << shamt;
    rd_shifted    = mem[word_idx] >> shamt;
    case (size_q)
      2'd0:    load_data = {56'd0, rd_shifted[7:0]};
      2'd1:    load_data = {48'd0, rd_shifted[15:0]};
      2'd2:    load_data = {32'd0, rd_shifted[31:0]};
      default: load_data = rd_shifted;
    endcase
  end

  // Byte-enabled write port; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (access_now && write_q && !acc_err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_shifted[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      size_q       <= 2'd0;
      read_data_q  <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            if (!write_q) begin
              read_data_q <= acc_err ? 64'd0 : load_data;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // req_valid still reflects the finishing instruction here.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign read_data  = read_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=128, LATENCY=2).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] read_data;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
    .resp_err(resp_err), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Presents one request and holds it until the DONE cycle; returns what DONE showed.
  task automatic run_op(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] s, output int stall_cycles, output logic err,
                        output logic [63:0] rdata, output logic done_stall);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = s;
    #1;
    stall_cycles = 0; err = 1'b0; rdata = '0; done_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) break;
      if (stall) stall_cycles++;
      @(negedge clk); #1;
    end
    if (resp_valid) begin
      err = resp_err; rdata = read_data; done_stall = stall;
    end else begin
      stall_cycles = 99;
    end
    req_valid = 1'b0;
    $display("op w=%0d addr=%h size=%0d wdata=%h -> stall=%0d err=%0d rdata=%h",
             w, a, s, d, stall_cycles, err, rdata);
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = 2'd0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (read_data !== 64'd0) begin errors++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_dword;
    int sc; logic e; logic [63:0] rd; logic ds;
    run_op(1'b1, 64'h10, 64'h0123456789ABCDEF, 2'd3, sc, e, rd, ds);
    checks++; if (sc !== 3) begin errors++; $display("FAIL store_stall_cycles: got %0d expected 3", sc); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err: got %b expected 0", e); end
    checks++; if (ds !== 1'b0) begin errors++; $display("FAIL done_stall: got %b expected 0", ds); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL store_keeps_rdata: got %h expected 0", rd); end
    run_op(1'b1, 64'h0, 64'h0, 2'd3, sc, e, rd, ds);
    run_op(1'b0, 64'h10, 64'h0, 2'd3, sc, e, rd, ds);
    checks++; if (rd !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL dword_load: got %h expected 0123456789abcdef", rd); end
    checks++; if (sc !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 3", sc); end
  endtask

  task automatic test_subword;
    int sc; logic e; logic [63:0] rd; logic ds;
    run_op(1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFAA, 2'd0, sc, e, rd, ds);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL byte_store_err: got %b expected 0", e); end
    checks++; if (rd !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL byte_store_keeps_rdata: got %h expected 0123456789abcdef", rd); end
    run_op(1'b0, 64'h10, 64'h0, 2'd3, sc, e, rd, ds);
    checks++; if (rd !== 64'h01234567AAABCDEF) begin errors++; $display("FAIL merged_dword: got %h expected 01234567aaabcdef", rd); end
    run_op(1'b0, 64'h13, 64'h0, 2'd0, sc, e, rd, ds);
    checks++; if (rd !== 64'h00000000000000AA) begin errors++; $display("FAIL byte_load: got %h expected aa", rd); end
    run_op(1'b0, 64'h12, 64'h0, 2'd1, sc, e, rd, ds);
    checks++; if (rd !== 64'h000000000000AAAB) begin errors++; $display("FAIL half_load: got %h expected aaab", rd); end
    run_op(1'b0, 64'h14, 64'h0, 2'd2, sc, e, rd, ds);
    checks++; if (rd !== 64'h0000000001234567) begin errors++; $display("FAIL word_load: got %h expected 01234567", rd); end
  endtask

  task automatic test_errors;
    int sc; logic e; logic [63:0] rd; logic ds;
    run_op(1'b0, 64'h12, 64'h0, 2'd2, sc, e, rd, ds);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_load_err: got %b expected 1", e); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL misaligned_load_data: got %h expected 0", rd); end
    checks++; if (sc !== 3) begin errors++; $display("FAIL err_stall_cycles: got %0d expected 3", sc); end
    run_op(1'b1, 64'h400, 64'hDEADBEEFCAFEF00D, 2'd3, sc, e, rd, ds);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_store_err: got %b expected 1", e); end
    run_op(1'b1, 64'h11, 64'hFFFF, 2'd1, sc, e, rd, ds);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_store_err: got %b expected 1", e); end
    run_op(1'b0, 64'h10, 64'h0, 2'd3, sc, e, rd, ds);
    checks++; if (rd !== 64'h01234567AAABCDEF) begin errors++; $display("FAIL mem_unchanged_10: got %h expected 01234567aaabcdef", rd); end
    run_op(1'b0, 64'h0, 64'h0, 2'd3, sc, e, rd, ds);
    checks++; if (rd !== 64'd0 || e !== 1'b0) begin errors++; $display("FAIL mem_unchanged_0: got %h err %b expected 0 err 0", rd, e); end
  endtask

  task automatic test_reset_mid_access;
    int sc; logic e; logic [63:0] rd; logic ds;
    run_op(1'b1, 64'h18, 64'h1122334455667788, 2'd3, sc, e, rd, ds);
    run_op(1'b0, 64'h10, 64'h0, 2'd3, sc, e, rd, ds);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18; req_wdata = '1; req_size = 2'd3;
    @(negedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    $display("reset pulsed during BUSY of store to 0x18");
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b expected 0", stall); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", req_ready); end
    checks++; if (read_data !== 64'd0) begin errors++; $display("FAIL midreset_read_data: got %h expected 0", read_data); end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    run_op(1'b0, 64'h18, 64'h0, 2'd3, sc, e, rd, ds);
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL aborted_store: got %h expected 1122334455667788", rd); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] stall_tr = '0;
    logic [9:0] resp_tr = '0;
    logic [63:0] first_rd = '0;
    logic [63:0] second_rd = '0;
    int pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 2'd3;
    #1;
    for (int i = 0; i < 10; i++) begin
      stall_tr = {stall_tr[8:0], stall};
      resp_tr  = {resp_tr[8:0], resp_valid};
      if (resp_valid) begin
        pulses++;
        if (pulses == 1) begin first_rd = read_data; req_addr = 64'h18; end
        else begin second_rd = read_data; req_valid = 1'b0; end
      end
      @(negedge clk); #1;
    end
    $display("back_to_back stall=%b resp=%b rd1=%h rd2=%h", stall_tr, resp_tr, first_rd, second_rd);
    checks++; if (stall_tr !== 10'b1110111000) begin errors++; $display("FAIL b2b_stall_trace: got %b expected 1110111000", stall_tr); end
    checks++; if (resp_tr !== 10'b0001000100) begin errors++; $display("FAIL b2b_resp_trace: got %b expected 0001000100", resp_tr); end
    checks++; if (first_rd !== 64'h01234567AAABCDEF) begin errors++; $display("FAIL b2b_first: got %h expected 01234567aaabcdef", first_rd); end
    checks++; if (second_rd !== 64'h1122334455667788) begin errors++; $display("FAIL b2b_second: got %h expected 1122334455667788", second_rd); end
  endtask

  initial begin
    test_reset();
    test_dword();
    test_subword();
    test_errors();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
